eth_counter_tx: RTL and testbench
=================================

ETH_COUNTER_TX -- requirements
Module: eth_counter_tx

Interface
REQ-001 Parameter PAYLOAD_LEN, default 46: payload bytes per frame, legal range 46..1500.
REQ-002 Parameter IFG_CYCLES, default 12: idle cycles between frames, legal range 0..255.
REQ-003 Parameter CNT_W, default 32: sequence/frame counter width, multiple of 8, CNT_W/8 <= PAYLOAD_LEN.
REQ-004 Parameter DST_MAC, default 48'hFFFF_FFFF_FFFF: destination address.
REQ-005 Parameter SRC_MAC, default 48'h0200_0000_0001: source address.
REQ-006 Parameter ETHERTYPE, default 16'h88B5: type field.
REQ-007 CLK  in  1  sole clock, all logic on rising edge.
REQ-008 RST_N  in  1  asynchronous, active-low reset.
REQ-009 EN  in  1  frame generation enable.
REQ-010 TX_TDATA  out  8  frame byte.
REQ-011 TX_TVALID  out  1  TX_TDATA valid.
REQ-012 TX_TLAST  out  1  last byte of frame.
REQ-013 TX_TREADY  in  1  downstream accepts byte.
REQ-014 FRAME_CNT  out  CNT_W  frames fully transmitted.
REQ-015 BUSY  out  1  high in any state other than IDLE.

Function
REQ-016 States IDLE, HDR, PAY, FCS, GAP; transfer = TX_TVALID && TX_TREADY.
REQ-017 IDLE: EN=1 -> HDR next cycle, TX_TVALID high that cycle (1-cycle latency); EN=0 -> remain.
REQ-018 HDR: 14 bytes, DST_MAC MSB first, SRC_MAC MSB first, ETHERTYPE MSB first; -> PAY after 14th transfer.
REQ-019 PAY: PAYLOAD_LEN bytes; first CNT_W/8 bytes = current sequence number big-endian, byte i thereafter = i[7:0] (i = payload index from 0).
REQ-020 Last PAY byte transfer -> FCS (with ETH_FCS_EN) or GAP (without).
REQ-021 TX_TDATA, TX_TLAST stable while TX_TVALID=1 and TX_TREADY=0; TX_TVALID never drops before transfer.
REQ-022 TX_TLAST high only on final frame byte.
REQ-023 Sequence number and FRAME_CNT increment by 1 on TX_TLAST transfer; both wrap 2^CNT_W-1 -> 0.
REQ-024 GAP: TX_TVALID=0 for exactly IFG_CYCLES cycles, then IDLE; IFG_CYCLES=0 -> direct to IDLE on the cycle after last transfer.
REQ-025 EN sampled only in IDLE; EN falling mid-frame does not truncate the frame.
REQ-026 TX_TREADY held low indefinitely: state frozen, no counter change.

Reset
REQ-027 RST_N low: state IDLE, TX_TVALID=0, TX_TLAST=0, TX_TDATA=0, BUSY=0, FRAME_CNT=0, sequence 0, byte index 0, CRC preset.
REQ-028 Reset mid-frame: outputs take reset values immediately, partial frame discarded, FRAME_CNT unchanged by it beyond clearing.
REQ-029 After RST_N rises, first frame starts no earlier than the first rising edge with EN=1.

Configuration
REQ-030 Macro ETH_COUNTER_FCS_EN defined: after payload, 4 FCS bytes emitted, CRC-32 IEEE 802.3 (reflected poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF) over header+payload, least-significant byte first, TX_TLAST on 4th byte.
REQ-031 Macro undefined: no FCS state or CRC logic; TX_TLAST on last payload byte; frame length 14+PAYLOAD_LEN.

Verification
REQ-032 Defaults, EN=1, TX_TREADY=1 -> 60 consecutive bytes (64 with FCS), bytes 0..5 = FF, byte 12..13 = 88 B5, bytes 14..17 = 00 00 00 00, TLAST on last byte, then 12 idle cycles.
REQ-033 ETH_COUNTER_FCS_EN, defaults, first frame -> FCS bytes match reference CRC-32 of bytes 0..59; receiver check of full 64 bytes yields residue 0xDEBB20E3.
REQ-034 TX_TREADY toggled pseudo-randomly 50% -> byte sequence identical to REQ-032, no byte duplicated or dropped, data stable during stalls.
REQ-035 CNT_W=8, EN=1 for 257 frames -> sequence bytes 00..FF then 00, FRAME_CNT=1 after frame 257.
REQ-036 RST_N low at payload byte 20 of frame 2 -> TX_TVALID=0 same cycle, FRAME_CNT=0; after release with EN=1 next frame carries sequence 00000000.
REQ-037 EN deasserted at header byte 3, IFG_CYCLES=0 -> frame completes, BUSY falls cycle after TLAST transfer, no further TX_TVALID.

Source files
------------

// File: rtl/eth_counter_tx.sv
// Counter-frame Ethernet transmitter: fixed header, sequence-stamped payload, optional FCS.
// Define ETH_COUNTER_FCS_EN to append a CRC-32 frame check sequence after the payload.
module eth_counter_tx #(
  parameter int          PAYLOAD_LEN = 46,
  parameter int          IFG_CYCLES  = 12,
  parameter int          CNT_W       = 32,
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  output logic [7:0]       TX_TDATA,
  output logic             TX_TVALID,
  output logic             TX_TLAST,
  input  logic             TX_TREADY,
  output logic [CNT_W-1:0] FRAME_CNT,
  output logic             BUSY,
  output logic [2:0]       DBG_STATE
);

  // Stream handshake: a byte moves on a rising edge where TX_TVALID && TX_TREADY.
  // Once TX_TVALID is high, TX_TDATA/TX_TLAST hold until that transfer happens.

  localparam int           SEQ_BYTES = CNT_W / 8;
  localparam logic [111:0] HDR_BYTES = {DST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [10:0]  PAY_LAST  = 11'(PAYLOAD_LEN - 1);
  localparam logic [10:0]  GAP_LAST  = 11'(IFG_CYCLES - 1);

`ifdef ETH_COUNTER_FCS_EN
  typedef enum logic [2:0] {IDLE, HDR, PAY, FCS, GAP} state_e;
`else
  typedef enum logic [2:0] {IDLE, HDR, PAY, GAP} state_e;
`endif

  // With no inter-frame gap the frame ends straight back in IDLE.
  localparam state_e END_STATE = (IFG_CYCLES == 0) ? IDLE : GAP;

  state_e           state_q, state_d;
  logic [10:0]      idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             xfer;

`ifdef ETH_COUNTER_FCS_EN
  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction
`endif

  assign xfer      = TX_TVALID && TX_TREADY;
  assign BUSY      = (state_q != IDLE);
  assign DBG_STATE = state_q;
  // The sequence number and the completed-frame count always move together.
  assign FRAME_CNT = cnt_q;

  always_comb begin
    TX_TDATA  = 8'h00;
    TX_TVALID = 1'b0;
    TX_TLAST  = 1'b0;
    case (state_q)
      HDR: begin
        TX_TVALID = 1'b1;
        for (int k = 0; k < 14; k++) begin
          if (idx_q == 11'(k)) TX_TDATA = HDR_BYTES[8*(13-k) +: 8];
        end
      end
      PAY: begin
        TX_TVALID = 1'b1;
        TX_TDATA  = idx_q[7:0];
        for (int k = 0; k < SEQ_BYTES; k++) begin
          if (idx_q == 11'(k)) TX_TDATA = cnt_q[8*(SEQ_BYTES-1-k) +: 8];
        end
`ifndef ETH_COUNTER_FCS_EN
        TX_TLAST = (idx_q == PAY_LAST);
`endif
      end
`ifdef ETH_COUNTER_FCS_EN
      FCS: begin
        TX_TVALID = 1'b1;
        TX_TLAST  = (idx_q == 11'd3);
        case (idx_q[1:0])
          2'd0:    TX_TDATA = ~crc_q[7:0];
          2'd1:    TX_TDATA = ~crc_q[15:8];
          2'd2:    TX_TDATA = ~crc_q[23:16];
          default: TX_TDATA = ~crc_q[31:24];
        endcase
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
`ifdef ETH_COUNTER_FCS_EN
    crc_d   = crc_q;
`endif
    case (state_q)
      IDLE: begin
        if (EN) begin
          state_d = HDR;
          idx_d   = 11'd0;
`ifdef ETH_COUNTER_FCS_EN
          crc_d   = 32'hFFFF_FFFF;
`endif
        end
      end
      HDR: begin
        if (xfer) begin
`ifdef ETH_COUNTER_FCS_EN
          crc_d = crc_byte(crc_q, TX_TDATA);
`endif
          if (idx_q == 11'd13) begin
            state_d = PAY;
            idx_d   = 11'd0;
          end else begin
            idx_d = idx_q + 11'd1;
          end
        end
      end
      PAY: begin
        if (xfer) begin
`ifdef ETH_COUNTER_FCS_EN
          crc_d = crc_byte(crc_q, TX_TDATA);
`endif
          if (idx_q == PAY_LAST) begin
            idx_d = 11'd0;
`ifdef ETH_COUNTER_FCS_EN
            state_d = FCS;
`else
            state_d = END_STATE;
            cnt_d   = cnt_q + CNT_W'(1);
`endif
          end else begin
            idx_d = idx_q + 11'd1;
          end
        end
      end
`ifdef ETH_COUNTER_FCS_EN
      FCS: begin
        if (xfer) begin
          if (idx_q == 11'd3) begin
            state_d = END_STATE;
            idx_d   = 11'd0;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            idx_d = idx_q + 11'd1;
          end
        end
      end
`endif
      GAP: begin
        if (idx_q == GAP_LAST) begin
          state_d = IDLE;
          idx_d   = 11'd0;
        end else begin
          idx_d = idx_q + 11'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q   <= 11'd0;
      cnt_q   <= '0;
`ifdef ETH_COUNTER_FCS_EN
      crc_q   <= 32'hFFFF_FFFF;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
`ifdef ETH_COUNTER_FCS_EN
      crc_q   <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_eth_counter_tx.sv
// Bench for eth_counter_tx: default instance for frame content, stalls and reset;
// a CNT_W=8 / IFG_CYCLES=0 instance for sequence wrap and EN-drop behaviour.
module tb_eth_counter_tx;

`ifdef ETH_COUNTER_FCS_EN
  localparam int FLEN = 64;
`else
  localparam int FLEN = 60;
`endif

  logic        clk;
  logic        rst_n;
  logic        en, tready;
  logic [7:0]  tdata;
  logic        tvalid, tlast, busy;
  logic [31:0] frame_cnt;
  logic [2:0]  dbg_state;

  logic        s_en, s_ready;
  logic [7:0]  s_data;
  logic        s_valid, s_last, s_busy;
  logic [7:0]  s_cnt;
  logic [2:0]  s_dbg;

  int checks = 0;
  int errors = 0;

  logic [8:0]  rx_q[$];
  logic        rand_ready = 1'b0;
  logic        hold_ready = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data  = 8'h00;
  logic        prev_last  = 1'b0;
  logic        s_xfer;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       last;
  } vec_t;
  vec_t tbl[12];

  eth_counter_tx u_dut (
    .CLK(clk), .RST_N(rst_n), .EN(en),
    .TX_TDATA(tdata), .TX_TVALID(tvalid), .TX_TLAST(tlast), .TX_TREADY(tready),
    .FRAME_CNT(frame_cnt), .BUSY(busy), .DBG_STATE(dbg_state)
  );

  eth_counter_tx #(.CNT_W(8), .IFG_CYCLES(0)) u_small (
    .CLK(clk), .RST_N(rst_n), .EN(s_en),
    .TX_TDATA(s_data), .TX_TVALID(s_valid), .TX_TLAST(s_last), .TX_TREADY(s_ready),
    .FRAME_CNT(s_cnt), .BUSY(s_busy), .DBG_STATE(s_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      r = (r[0] ^ d[b]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  // driver + monitor for the default instance, one cycle per call
  task automatic step();
    @(negedge clk);
    if (prev_stall) chk("stall_hold", {22'd0, tvalid, tlast, tdata}, {22'd0, 1'b1, prev_last, prev_data});
    tready = hold_ready ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    if (tvalid && tready) rx_q.push_back({tlast, tdata});
    prev_stall = tvalid && !tready;
    prev_data  = tdata;
    prev_last  = tlast;
  endtask

  task automatic s_step();
    @(negedge clk);
    s_xfer = s_valid && s_ready;
  endtask

  task automatic wait_frame();
    int n = 0;
    while (!(rx_q.size() > 0 && rx_q[rx_q.size()-1][8]) && n < 4000) begin
      step();
      n++;
    end
    chk("frame_done", {31'd0, n < 4000}, 32'd1);
  endtask

  // scoreboard: expected bytes built from the frame definition
  task automatic check_frame(input logic [31:0] seq);
    logic [7:0]   exp_q[$];
    logic [111:0] hdr;
    logic [31:0]  c;
    hdr = {48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h88B5};
    for (int i = 0; i < 14; i++) exp_q.push_back(hdr[111-8*i -: 8]);
    for (int p = 0; p < 46; p++) begin
      if (p < 4) exp_q.push_back(seq[31-8*p -: 8]);
      else       exp_q.push_back(p[7:0]);
    end
`ifdef ETH_COUNTER_FCS_EN
    c = 32'hFFFF_FFFF;
    foreach (exp_q[i]) c = ref_crc(c, exp_q[i]);
    c = ~c;
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[23:16]);
    exp_q.push_back(c[31:24]);
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < rx_q.size(); i++) c = ref_crc(c, rx_q[i][7:0]);
    chk("fcs_residue", c, 32'hDEBB_20E3);
`else
    c = 32'd0;
`endif
    chk("frame_len", rx_q.size(), FLEN);
    for (int i = 0; i < FLEN && i < rx_q.size(); i++) begin
      chk($sformatf("byte%0d_seq%0h", i, seq), {23'd0, rx_q[i]},
          {23'd0, (i == FLEN - 1), exp_q[i]});
    end
  endtask

  initial begin
    int n;
    int frames;
    int bcnt;
    int vcnt;

    rst_n = 1'b0; en = 1'b0; tready = 1'b1; s_en = 1'b0; s_ready = 1'b1;
    s_xfer = 1'b0;
    tbl[0]  = '{0,  8'hFF, 1'b0};
    tbl[1]  = '{5,  8'hFF, 1'b0};
    tbl[2]  = '{6,  8'h02, 1'b0};
    tbl[3]  = '{11, 8'h01, 1'b0};
    tbl[4]  = '{12, 8'h88, 1'b0};
    tbl[5]  = '{13, 8'hB5, 1'b0};
    tbl[6]  = '{14, 8'h00, 1'b0};
    tbl[7]  = '{17, 8'h00, 1'b0};
    tbl[8]  = '{18, 8'h04, 1'b0};
    tbl[9]  = '{30, 8'h10, 1'b0};
`ifdef ETH_COUNTER_FCS_EN
    tbl[10] = '{59, 8'h2D, 1'b0};
`else
    tbl[10] = '{59, 8'h2D, 1'b1};
`endif
    tbl[11] = '{FLEN - 1, 8'h00, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_tvalid", {31'd0, tvalid}, 0);
    chk("rst_tlast", {31'd0, tlast}, 0);
    chk("rst_tdata", {24'd0, tdata}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_frame_cnt", frame_cnt, 0);

    rst_n = 1'b1;
    vcnt = 0;
    repeat (5) begin step(); if (tvalid || busy) vcnt++; end
    chk("idle_without_en", vcnt, 0);

    // first frame, full rate
    en = 1'b1;
    step();
    chk("start_latency", {23'd0, tvalid, tdata}, {23'd0, 1'b1, 8'hFF});
    wait_frame();
    for (int i = 0; i < 12; i++) begin
      if (i == 11) begin
        if (FLEN != 64) continue;
      end
      chk($sformatf("tbl_byte%0d", tbl[i].idx), {23'd0, rx_q[tbl[i].idx]},
          {23'd0, tbl[i].last, tbl[i].data});
    end
    check_frame(32'd0);

    n = 0;
    step();
    while (busy && !tvalid && n < 300) begin n++; step(); end
    chk("gap_cycles", n, 12);
    chk("idle_after_gap", {30'd0, busy, tvalid}, 0);
    chk("frame_cnt_1", frame_cnt, 1);

    // second frame with random backpressure
    rx_q.delete();
    rand_ready = 1'b1;
    wait_frame();
    rand_ready = 1'b0;
    check_frame(32'd1);
    step();
    chk("frame_cnt_2", frame_cnt, 2);

    // reset at payload byte 20 of the next frame
    rx_q.delete();
    n = 0;
    while (rx_q.size() != 35 && n < 2000) begin step(); n++; end
    chk("reach_pay20", rx_q.size(), 35);
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", {31'd0, tvalid}, 0);
    chk("midrst_out", {22'd0, busy, tlast, tdata}, 0);
    chk("midrst_frame_cnt", frame_cnt, 0);
    repeat (3) @(negedge clk);
    rx_q.delete();
    prev_stall = 1'b0;
    rst_n = 1'b1;

    // frame after reset, with a long stall on header byte 12
    n = 0;
    while (rx_q.size() != 12 && n < 200) begin step(); n++; end
    hold_ready = 1'b1;
    repeat (40) step();
    chk("stall_state", {22'd0, busy, tvalid, tdata}, {22'd0, 1'b1, 1'b1, 8'h88});
    chk("stall_frame_cnt", frame_cnt, 0);
    hold_ready = 1'b0;
    wait_frame();
    check_frame(32'd0);
    en = 1'b0;
    step();
    chk("frame_cnt_after_rst", frame_cnt, 1);

    // CNT_W=8 instance: 257 back-to-back frames, sequence wraps
    s_en = 1'b1;
    frames = 0;
    bcnt = 0;
    n = 0;
    while (frames < 257 && n < 40000) begin
      s_step();
      n++;
      if (s_xfer) begin
        if (bcnt == 14) chk($sformatf("seq_frame%0d", frames), {24'd0, s_data}, {24'd0, 8'(frames)});
        if (s_last) begin
          frames++;
          bcnt = 0;
          if (frames == 257) s_en = 1'b0;
        end else begin
          bcnt++;
        end
      end
    end
    chk("wrap_frames", frames, 257);
    s_step();
    chk("wrap_frame_cnt", {24'd0, s_cnt}, 1);
    chk("wrap_idle", {31'd0, s_busy}, 0);

    // EN dropped during header byte 3 does not truncate the frame
    s_en = 1'b1;
    bcnt = 0;
    n = 0;
    while (n < 500) begin
      s_step();
      n++;
      if (s_xfer) begin
        if (bcnt == 3) s_en = 1'b0;
        if (s_last) break;
        bcnt++;
      end
    end
    chk("en_drop_len", bcnt, FLEN - 1);
    s_step();
    chk("en_drop_busy", {30'd0, s_busy, s_valid}, 0);
    vcnt = 0;
    repeat (20) begin s_step(); if (s_valid) vcnt++; end
    chk("en_drop_no_valid", vcnt, 0);
    chk("en_drop_frame_cnt", {24'd0, s_cnt}, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
